// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the word-memory read path.
//   WORDSIZE  - data word width
//   MEMSIZE   - address width
//   MEMDEPTH  - number of words in the memory
//   rd_state_e - reader FSM state encoding
package mem_pkg;

  localparam int WORDSIZE = 16;
  localparam int MEMSIZE  = 3;
  localparam int MEMDEPTH = 2 ** MEMSIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/mem_rd_fifo2.sv
// mem_rd_fifo2: 2-entry FIFO with registered head, used as the output
// buffer of the memory reader.
//   clk, rst : clock, asynchronous active-low reset
//   push/din : write strobe and data
//   pop      : read strobe (caller guarantees count != 0)
//   dout     : head entry (registered)
//   count    : occupancy 0..2
module mem_rd_fifo2 #(
  parameter int wordsize = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [wordsize-1:0] din,
  input  logic                pop,
  output logic [wordsize-1:0] dout,
  output logic [1:0]          count
);

  logic [wordsize-1:0] head_q;
  logic [wordsize-1:0] tail_q;
  logic [1:0]          cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= din;
          else               tail_q <= din;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          // count unchanged; with two entries the tail moves up to the head
          if (cnt_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= din;
          end else begin
            head_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = head_q;
  assign count = cnt_q;

endmodule

// File: rtl/mem_rd_stream.sv
// mem_rd_stream: on a start command, reads `length` words from a
// synchronous-read memory beginning at `base_addr` (wrapping modulo the
// memory depth) and returns them in order on a valid/ready stream.
//   clk, rst             : clock, asynchronous active-low reset
//   start                : command pulse, honoured only while idle
//   base_addr, length    : command parameters, captured on accepted start
//   mem_rd_en, mem_addr  : memory read port request
//   mem_rdata            : memory data, valid the cycle after mem_rd_en
//   data_out, out_valid  : output stream
//   out_ready            : consumer ready
//   busy                 : command in progress
//   done                 : pulse with the final word transfer (or the
//                          cycle after a zero-length start)
module mem_rd_stream
  import mem_pkg::*;
#(
  parameter int wordsize = WORDSIZE,
  parameter int memsize  = MEMSIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [memsize-1:0]  base_addr,
  input  logic [memsize:0]    length,
  output logic                mem_rd_en,
  output logic [memsize-1:0]  mem_addr,
  input  logic [wordsize-1:0] mem_rdata,
  output logic [wordsize-1:0] data_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done
);

  localparam logic [memsize:0] CNT_ONE = {{memsize{1'b0}}, 1'b1};

  rd_state_e          state_q, state_d;
  logic [memsize-1:0] base_q;
  logic [memsize-1:0] addr_q;
  logic [memsize-1:0] issue_addr;
  logic [memsize:0]   len_q;
  logic [memsize:0]   issued_q;
  logic [memsize:0]   delivered_q;
  logic               inflight_q;
  logic               zero_done_q;
  logic [1:0]         fifo_count;
  logic [2:0]         credits_used;
  logic               pop;
  logic               last_pop;
  logic               start_ok;

  assign start_ok  = (state_q == IDLE) && start;
  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid && out_ready;

  // Credits count what will still occupy the FIFO after this cycle's pop,
  // plus the read already in flight. Discounting the pop is what lets a
  // new read issue every cycle while the consumer keeps draining.
  assign credits_used = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

  assign issue_addr = base_q + issued_q[memsize-1:0];
  assign mem_rd_en  = (state_q == READ) && (credits_used < 3'd2);
  assign mem_addr   = mem_rd_en ? issue_addr : addr_q;

  assign last_pop = pop && ((delivered_q + CNT_ONE) == len_q);
  assign done     = zero_done_q || ((state_q == DRAIN) && last_pop);
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (length != '0)) state_d = READ;
      READ:    if (mem_rd_en && ((issued_q + CNT_ONE) == len_q)) state_d = DRAIN;
      DRAIN:   if (last_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= mem_rd_en;
      zero_done_q <= start_ok && (length == '0);
      if (mem_rd_en) begin
        issued_q <= issued_q + CNT_ONE;
        addr_q   <= issue_addr;
      end
      if (pop) delivered_q <= delivered_q + CNT_ONE;
      if (start_ok) begin
        base_q      <= base_addr;
        len_q       <= length;
        issued_q    <= '0;
        delivered_q <= '0;
      end
    end
  end

  mem_rd_fifo2 #(.wordsize(wordsize)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (mem_rdata),
    .pop   (pop),
    .dout  (data_out),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_mem_rd_stream.sv
module tb_mem_rd_stream;
  import mem_pkg::*;

  localparam int W = 16;
  localparam int M = 3;

  logic         clk;
  logic         rst;
  logic         start;
  logic [M-1:0] base_addr;
  logic [M:0]   length;
  logic         mem_rd_en;
  logic [M-1:0] mem_addr;
  logic [W-1:0] mem_rdata;
  logic [W-1:0] data_out;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         done;

  mem_rd_stream dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read memory
  logic [W-1:0] mem [MEMDEPTH];
  initial mem_rdata = '0;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + compare process ----------------
  logic [M-1:0] exp_addr_q [$];
  logic [W-1:0] exp_data_q [$];
  logic [M-1:0] addr_log   [$];
  logic [W-1:0] data_log   [$];
  int           data_cyc   [$];
  bit           m_busy      = 0;
  bit           m_zero_done = 0;
  bit           prev_stall  = 0;
  logic [W-1:0] prev_data   = '0;
  int           outstanding = 0;
  int           cyc         = 0;
  int           rd_count    = 0;
  int           done_count  = 0;
  int           start_cyc   = 0;

  always @(negedge clk) begin
    bit exp_done;
    bit next_busy;
    cyc++;
    if (!rst) begin
      exp_addr_q.delete();
      exp_data_q.delete();
      m_busy      = 0;
      m_zero_done = 0;
      prev_stall  = 0;
      outstanding = 0;
    end else begin
      check("busy", busy, m_busy);
      if (!m_busy) check("idle_valid", out_valid, 1'b0);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", data_out, prev_data);
      end
      exp_done  = m_zero_done;
      next_busy = m_busy;
      if (mem_rd_en) begin
        rd_count++;
        addr_log.push_back(mem_addr);
        check("credit", ((outstanding - int'(out_valid && out_ready)) < 2), 1'b1);
        if (exp_addr_q.size() == 0) check("unexpected_read", 1'b1, 1'b0);
        else check("mem_addr", mem_addr, exp_addr_q.pop_front());
        outstanding++;
      end
      if (out_valid && out_ready) begin
        data_log.push_back(data_out);
        data_cyc.push_back(cyc);
        if (exp_data_q.size() == 0) check("unexpected_word", 1'b1, 1'b0);
        else check("data_out", data_out, exp_data_q.pop_front());
        outstanding--;
        if (m_busy && exp_data_q.size() == 0) begin
          exp_done  = 1;
          next_busy = 0;
        end
      end
      check("done", done, exp_done);
      if (done) done_count++;
      m_zero_done = 0;
      if (start && !m_busy) begin
        start_cyc = cyc;
        if (length == 0) m_zero_done = 1;
        else begin
          next_busy = 1;
          for (int i = 0; i < int'(length); i++) begin
            logic [M-1:0] a;
            a = 3'((int'(base_addr) + i) % MEMDEPTH);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(mem[a]);
          end
        end
      end
      m_busy     = next_busy;
      prev_stall = out_valid && !out_ready;
      prev_data  = data_out;
    end
  end

  // ---------------- consumer ready driver ----------------
  int ready_mode = 0;  // 0 always, 1 toggle, 2 random, 3 held low
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int b, input int l);
    start     = 1'b1;
    base_addr = 3'(b);
    length    = 4'(l);
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while ((m_busy || m_zero_done || exp_data_q.size() != 0) && k < budget) begin
      step(1);
      k++;
    end
    if (k >= budget) check({name, "_timeout"}, 1'b1, 1'b0);
    step(2);
  endtask

  task automatic check_words(input string name, input int first, input int n, input int base);
    check({name, "_count"}, data_log.size() - first, n);
    for (int i = 0; i < n && first + i < data_log.size(); i++)
      check(name, data_log[first+i], 16'h1000 + 16'((base + i) % MEMDEPTH));
  endtask

  initial begin
    int d0, a0, r0, c0;
    rst       = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    for (int i = 0; i < MEMDEPTH; i++) mem[i] = 16'h1000 + 16'(i);
    step(3);
    check("rst_rd_en", mem_rd_en, 1'b0);
    check("rst_addr", mem_addr, 3'd0);
    check("rst_data", data_out, 16'h0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b1;
    ready_mode = 0;
    step(3);

    // full sweep, no backpressure
    d0 = data_log.size(); c0 = done_count;
    do_start(0, 8);
    wait_idle("t1", 100);
    check_words("t1_word", d0, 8, 0);
    if (data_log.size() - d0 == 8) begin
      check("t1_latency", data_cyc[d0] - start_cyc, 3);
      check("t1_back2back", data_cyc[d0+7] - data_cyc[d0], 7);
    end
    check("t1_done_count", done_count - c0, 1);

    // wrap-around
    d0 = data_log.size(); a0 = addr_log.size();
    do_start(6, 4);
    wait_idle("t2", 100);
    check_words("t2_word", d0, 4, 6);
    check("t2_addr_count", addr_log.size() - a0, 4);
    if (addr_log.size() - a0 == 4)
      check("t2_addr_seq", {addr_log[a0], addr_log[a0+1], addr_log[a0+2], addr_log[a0+3]},
            {3'd6, 3'd7, 3'd0, 3'd1});

    // toggling ready
    ready_mode = 1;
    step(1);
    d0 = data_log.size();
    do_start(2, 5);
    wait_idle("t3", 100);
    check_words("t3_word", d0, 5, 2);

    // zero length, then start while busy
    ready_mode = 0;
    step(2);
    r0 = rd_count; c0 = done_count;
    do_start(1, 0);
    step(3);
    check("t4_zero_reads", rd_count - r0, 0);
    check("t4_zero_done", done_count - c0, 1);
    d0 = data_log.size();
    do_start(0, 3);
    do_start(5, 7);
    wait_idle("t4", 100);
    check_words("t4_word", d0, 3, 0);

    // reset mid-transfer
    d0 = data_log.size();
    do_start(0, 8);
    begin
      int k = 0;
      while (data_log.size() - d0 < 2 && k < 50) begin step(1); k++; end
      if (k >= 50) check("t5_wait_timeout", 1'b1, 1'b0);
    end
    #2;
    rst = 1'b0;
    #1;
    check("t5_rd_en", mem_rd_en, 1'b0);
    check("t5_addr", mem_addr, 3'd0);
    check("t5_data", data_out, 16'h0);
    check("t5_valid", out_valid, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_done", done, 1'b0);
    step(2);
    rst = 1'b1;
    step(2);
    d0 = data_log.size();
    do_start(4, 2);
    wait_idle("t5", 100);
    check_words("t5_word", d0, 2, 4);

    // long stall
    ready_mode = 3;
    step(2);
    r0 = rd_count; d0 = data_log.size();
    do_start(0, 3);
    step(9);
    check("t6_reads", rd_count - r0, 2);
    check("t6_valid", out_valid, 1'b1);
    check("t6_head", data_out, 16'h1000);
    ready_mode = 0;
    wait_idle("t6", 100);
    check_words("t6_word", d0, 3, 0);

    // randomized commands against the model
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < MEMDEPTH; i++) mem[i] = 16'($urandom);
      ready_mode = ($urandom_range(0, 3) == 0) ? 0 : 2;
      step($urandom_range(0, 3));
      do_start($urandom_range(0, 7), $urandom_range(0, 8));
      if ($urandom_range(0, 4) == 0) do_start($urandom_range(0, 7), $urandom_range(1, 8));
      wait_idle("rand", 300);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
